// File: rtl/pulse_trigger_gen_if.sv
// Control/status bundle for pulse_trigger_gen: trigger and phase settings in,
// pulse output and sequence status out.
interface pulse_trigger_gen_if #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned NUM_W = 4
);
    logic             on;
    logic             mode;
    logic [CNT_W-1:0] delay_len;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] low_len;
    logic [NUM_W-1:0] num_pulses;
    logic             signal;
    logic             busy;
    logic             done;
    logic [NUM_W-1:0] pulse_cnt;

    modport master (
        output on, mode, delay_len, high_len, low_len, num_pulses,
        input  signal, busy, done, pulse_cnt
    );

    modport slave (
        input  on, mode, delay_len, high_len, low_len, num_pulses,
        output signal, busy, done, pulse_cnt
    );
endinterface

// File: rtl/pulse_trigger_gen.sv
// Programmable pulse generator: optional start delay, then a burst of N pulses or a
// continuous high/low train gated by the trigger level.
module pulse_trigger_gen #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned NUM_W = 4
) (
    input logic               clock,
    input logic               reset,
    pulse_trigger_gen_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StDelay, StHigh, StLow} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic             on_q, signal_q, done_q;
    logic             mode_q;
    logic [CNT_W-1:0] high_q, low_q;
    logic [NUM_W-1:0] num_q;
    logic             start, latch_en, last_pulse;
    logic [NUM_W-1:0] pulse_inc;

    // Phase counter is loaded with length-1 so that a zero length behaves as one cycle.
    function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - CNT_W'(1);
    endfunction

    assign start      = bus.on & ~on_q;
    assign pulse_inc  = (pulse_cnt_q == '1) ? pulse_cnt_q : pulse_cnt_q + NUM_W'(1);
    assign last_pulse = (pulse_inc == num_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        latch_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    latch_en    = 1'b1;
                    pulse_cnt_d = '0;
                    // A zero-pulse burst still passes through DELAY so it completes with done.
                    if (bus.delay_len != '0 || (!bus.mode && bus.num_pulses == '0)) begin
                        state_d = StDelay;
                        cnt_d   = len_m1(bus.delay_len);
                    end else begin
                        state_d = StHigh;
                        cnt_d   = len_m1(bus.high_len);
                    end
                end
            end
            StDelay: begin
                if (mode_q && !bus.on) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    if (!mode_q && num_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StHigh;
                        cnt_d   = len_m1(high_q);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StHigh: begin
                if (cnt_q == '0) begin
                    pulse_cnt_d = pulse_inc;
                    if (mode_q ? !bus.on : last_pulse) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StLow;
                        cnt_d   = len_m1(low_q);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StLow: begin
                if (mode_q && !bus.on) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StHigh;
                    cnt_d   = len_m1(high_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            pulse_cnt_q <= '0;
            on_q        <= 1'b0;
            signal_q    <= 1'b0;
            done_q      <= 1'b0;
            mode_q      <= 1'b0;
            high_q      <= '0;
            low_q       <= '0;
            num_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            on_q        <= bus.on;
            signal_q    <= (state_d == StHigh);
            done_q      <= (state_q != StIdle) && (state_d == StIdle);
            if (latch_en) begin
                mode_q <= bus.mode;
                high_q <= bus.high_len;
                low_q  <= bus.low_len;
                num_q  <= bus.num_pulses;
            end
        end
    end

    assign bus.signal    = signal_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = done_q;
    assign bus.pulse_cnt = pulse_cnt_q;
endmodule

// File: tb/tb_pulse_trigger_gen.sv
// Directed bench for pulse_trigger_gen: one 8/4-bit instance and one with a 2-bit pulse count.
module tb_pulse_trigger_gen;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    pulse_trigger_gen_if #(.CNT_W(8), .NUM_W(4)) ifa ();
    pulse_trigger_gen_if #(.CNT_W(8), .NUM_W(2)) ifb ();

    pulse_trigger_gen #(.CNT_W(8), .NUM_W(4)) dut_a (.clock(clock), .reset(reset), .bus(ifa));
    pulse_trigger_gen #(.CNT_W(8), .NUM_W(2)) dut_b (.clock(clock), .reset(reset), .bus(ifb));

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_a(input logic m, input int d, input int h, input int l, input int n);
        ifa.mode = m; ifa.delay_len = 8'(d); ifa.high_len = 8'(h);
        ifa.low_len = 8'(l); ifa.num_pulses = 4'(n);
    endtask

    task automatic set_b(input logic m, input int d, input int h, input int l, input int n);
        ifb.mode = m; ifb.delay_len = 8'(d); ifb.high_len = 8'(h);
        ifb.low_len = 8'(l); ifb.num_pulses = 2'(n);
    endtask

    task automatic test_reset();
        ifa.on = 1'b1; ifb.on = 1'b1;
        reset = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({ifa.signal, ifa.busy, ifa.done, ifa.pulse_cnt} !== 7'b0) begin
            n_err++; $display("FAIL reset.a got %b want 0", {ifa.signal, ifa.busy, ifa.done, ifa.pulse_cnt});
        end
        n_cmp++;
        if ({ifb.signal, ifb.busy, ifb.done, ifb.pulse_cnt} !== 5'b0) begin
            n_err++; $display("FAIL reset.b got %b want 0", {ifb.signal, ifb.busy, ifb.done, ifb.pulse_cnt});
        end
        ifa.on = 1'b0; ifb.on = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_burst();
        int highs = 0;
        logic [14:0] exp_sig = 15'b000011011011000;
        ifa.on = 1'b0; set_a(1'b0, 3, 2, 1, 3); tick();
        ifa.on = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (i == 0) set_a(1'b1, 7, 5, 5, 1); // latched values must win
            highs += int'(ifa.signal);
            n_cmp++;
            if (ifa.signal !== exp_sig[i]) begin
                n_err++; $display("FAIL burst.signal i=%0d got %b want %b", i, ifa.signal, exp_sig[i]);
            end
            n_cmp++;
            if (ifa.busy !== (i < 11)) begin
                n_err++; $display("FAIL burst.busy i=%0d got %b want %b", i, ifa.busy, (i < 11));
            end
            n_cmp++;
            if (ifa.done !== (i == 11)) begin
                n_err++; $display("FAIL burst.done i=%0d got %b want %b", i, ifa.done, (i == 11));
            end
        end
        n_cmp++;
        if (ifa.pulse_cnt !== 4'd3) begin
            n_err++; $display("FAIL burst.pulse_cnt got %0d want 3", ifa.pulse_cnt);
        end
        n_cmp++;
        if (highs != 6) begin
            n_err++; $display("FAIL burst.high_cycles got %0d want 6", highs);
        end
    endtask

    task automatic test_zero_len();
        logic [4:0] exp_sig = 5'b00101;
        ifa.on = 1'b0; set_a(1'b0, 0, 0, 0, 2); tick();
        ifa.on = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({ifa.signal, ifa.busy, ifa.done} !== {exp_sig[i], (i < 3), (i == 3)}) begin
                n_err++; $display("FAIL zero_len i=%0d sig/busy/done got %b want %b", i,
                    {ifa.signal, ifa.busy, ifa.done}, {exp_sig[i], (i < 3), (i == 3)});
            end
        end
        n_cmp++;
        if (ifa.pulse_cnt !== 4'd2) begin
            n_err++; $display("FAIL zero_len.pulse_cnt got %0d want 2", ifa.pulse_cnt);
        end
    endtask

    task automatic test_cont_high_drop();
        logic [15:0] exp_sig = 16'h1CE7;
        ifa.on = 1'b0; set_a(1'b1, 0, 3, 2, 0); tick();
        ifa.on = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 12) ifa.on = 1'b0;
            tick();
            n_cmp++;
            if ({ifa.signal, ifa.busy, ifa.done} !== {exp_sig[i], (i < 13), (i == 13)}) begin
                n_err++; $display("FAIL cont_high_drop i=%0d sig/busy/done got %b want %b", i,
                    {ifa.signal, ifa.busy, ifa.done}, {exp_sig[i], (i < 13), (i == 13)});
            end
        end
        n_cmp++;
        if (ifa.pulse_cnt !== 4'd3) begin
            n_err++; $display("FAIL cont_high_drop.pulse_cnt got %0d want 3", ifa.pulse_cnt);
        end
    endtask

    task automatic test_cont_low_drop();
        logic [5:0] exp_sig = 6'b000011;
        ifa.on = 1'b0; set_a(1'b1, 0, 2, 3, 0); tick();
        ifa.on = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) ifa.on = 1'b0;
            tick();
            n_cmp++;
            if ({ifa.signal, ifa.busy, ifa.done} !== {exp_sig[i], (i < 3), (i == 3)}) begin
                n_err++; $display("FAIL cont_low_drop i=%0d sig/busy/done got %b want %b", i,
                    {ifa.signal, ifa.busy, ifa.done}, {exp_sig[i], (i < 3), (i == 3)});
            end
        end
        n_cmp++;
        if (ifa.pulse_cnt !== 4'd1) begin
            n_err++; $display("FAIL cont_low_drop.pulse_cnt got %0d want 1", ifa.pulse_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic es, eb;
        ifa.on = 1'b0; set_a(1'b0, 3, 2, 1, 3); tick();
        ifa.on = 1'b1;
        for (int i = 0; i < 20; i++) begin
            reset = (i >= 4 && i <= 6);
            tick();
            // Reset clears on_q, so the still-high trigger restarts at i=7.
            es = (i == 3) || (i >= 10 && i <= 17 && i != 12 && i != 15);
            eb = (i < 4) || (i >= 7 && i < 18);
            n_cmp++;
            if ({ifa.signal, ifa.busy, ifa.done} !== {es, eb, (i == 18)}) begin
                n_err++; $display("FAIL reset_mid i=%0d sig/busy/done got %b want %b", i,
                    {ifa.signal, ifa.busy, ifa.done}, {es, eb, (i == 18)});
            end
            if (i >= 4 && i <= 6) begin
                n_cmp++;
                if (ifa.pulse_cnt !== 4'd0) begin
                    n_err++; $display("FAIL reset_mid.pulse_cnt i=%0d got %0d want 0", i, ifa.pulse_cnt);
                end
            end
        end
        reset = 1'b0;
        n_cmp++;
        if (ifa.pulse_cnt !== 4'd3) begin
            n_err++; $display("FAIL reset_mid.final_cnt got %0d want 3", ifa.pulse_cnt);
        end
        ifa.on = 1'b0; tick();
    endtask

    task automatic test_saturation();
        ifb.on = 1'b0; set_b(1'b1, 0, 1, 1, 0); tick();
        ifb.on = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        n_cmp++;
        if ({ifb.busy, ifb.pulse_cnt} !== 3'b111) begin
            n_err++; $display("FAIL saturation.running busy/cnt got %b want 111", {ifb.busy, ifb.pulse_cnt});
        end
        ifb.on = 1'b0;
        tick();
        n_cmp++;
        if ({ifb.busy, ifb.done, ifb.pulse_cnt} !== 4'b0111) begin
            n_err++; $display("FAIL saturation.end busy/done/cnt got %b want 0111",
                {ifb.busy, ifb.done, ifb.pulse_cnt});
        end
    endtask

    task automatic test_back_to_back();
        logic es;
        ifb.on = 1'b0; set_b(1'b0, 1, 2, 2, 3); tick();
        ifb.on = 1'b1;
        for (int i = 0; i < 13; i++) begin
            tick();
            if (i == 1) set_b(1'b1, 0, 1, 1, 1);
            ifb.on = (i >= 8) ? 1'b1 : (i % 2 == 1); // rising edges while busy
            es = (i == 1) || (i == 2) || (i == 5) || (i == 6) || (i == 9) || (i == 10);
            n_cmp++;
            if ({ifb.signal, ifb.busy, ifb.done} !== {es, (i < 11), (i == 11)}) begin
                n_err++; $display("FAIL back_to_back i=%0d sig/busy/done got %b want %b", i,
                    {ifb.signal, ifb.busy, ifb.done}, {es, (i < 11), (i == 11)});
            end
        end
        n_cmp++;
        if (ifb.pulse_cnt !== 2'd3) begin
            n_err++; $display("FAIL back_to_back.pulse_cnt got %0d want 3", ifb.pulse_cnt);
        end
    endtask

    task automatic test_zero_num();
        ifb.on = 1'b0; set_b(1'b0, 2, 1, 1, 0); tick();
        ifb.on = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({ifb.signal, ifb.busy, ifb.done} !== {1'b0, (i < 2), (i == 2)}) begin
                n_err++; $display("FAIL zero_num i=%0d sig/busy/done got %b want %b", i,
                    {ifb.signal, ifb.busy, ifb.done}, {1'b0, (i < 2), (i == 2)});
            end
        end
        n_cmp++;
        if (ifb.pulse_cnt !== 2'd0) begin
            n_err++; $display("FAIL zero_num.pulse_cnt got %0d want 0", ifb.pulse_cnt);
        end
    endtask

    initial begin
        ifa.on = 1'b0; set_a(1'b0, 0, 0, 0, 0);
        ifb.on = 1'b0; set_b(1'b0, 0, 0, 0, 0);
        test_reset();
        test_burst();
        test_zero_len();
        test_cont_high_drop();
        test_cont_low_drop();
        test_reset_mid();
        test_saturation();
        test_back_to_back();
        test_zero_num();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
